// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg -- shared types and constants for the adder tree sequencer.
//   seq_state_t  : sequencer FSM state (IDLE, FEED, DRAIN, OUTPUT)
//   tag_t        : {valid, last} tag that travels alongside each tree beat
//   ACC_W        : accumulator / tree root width
//   tree_latency : beat-to-root latency of a pipelined adder tree of a given breadth
package adder_tree_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_OUTPUT
  } seq_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  // One register per adder level plus the input register.
  function automatic int tree_latency(input int breadth);
    return $clog2(breadth) + 1;
  endfunction

endpackage

// File: rtl/adder_tree_sequencer_if.sv
// adder_tree_sequencer_if -- stream-side signals of the sequencer.
//   in_valid / in_ready : upstream vector handshake
//   tree_load           : a vector enters the adder tree this cycle
//   tree_sum            : raw root sum returned by the tree
//   out_valid/out_ready : result handshake
//   out_data / out_acc  : rectified result and raw signed accumulator
// Modports: slave = sequencer, master = surrounding environment.
interface adder_tree_sequencer_if #(
  parameter int DATA_BITWIDTH = 8
);
  import adder_tree_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic                     tree_load;
  logic [ACC_W-1:0]         tree_sum;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_BITWIDTH-1:0] out_data;
  logic [ACC_W-1:0]         out_acc;

  modport master (
    output in_valid, tree_sum, out_ready,
    input  in_ready, tree_load, out_valid, out_data, out_acc
  );

  modport slave (
    input  in_valid, tree_sum, out_ready,
    output in_ready, tree_load, out_valid, out_data, out_acc
  );

endinterface

// File: rtl/tag_delay_line.sv
// tag_delay_line -- DEPTH-stage shift register of tags that mirrors the adder
// tree pipeline, so each root sum arrives together with its own tag.
//   clk, rst : clock, synchronous active-high reset
//   tag_in   : tag pushed this cycle ({0,0} when no beat is launched)
//   tag_out  : tag belonging to the current tree root sum
module tag_delay_line
  import adder_tree_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  // NOTE: every stage is reset on purpose; clearing the tags is what discards
  // sums still in flight in the tree when a job is abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/adder_tree_sequencer.sv
// adder_tree_sequencer -- feeds cfg_chunks vectors into an external adder
// tree, accumulates the returning root sums and emits a ReLU-rectified result.
//   clk, rst          : clock, synchronous active-high reset
//   start, cfg_chunks : job start pulse and vectors per job (0 means 1)
//   cfg_bias          : accumulator initial value, only when the build macro
//                       ADDER_TREE_SEQ_BIAS_EN is defined (otherwise init is 0)
//   busy, done        : job in progress, one-cycle completion pulse
//   bus (slave)       : input/tree/output stream signals
module adder_tree_sequencer
  import adder_tree_pkg::*;
#(
  parameter int DATA_BITWIDTH   = 8,
  parameter int BREADTH_OF_TREE = 32,
  parameter int TREE_LATENCY    = tree_latency(BREADTH_OF_TREE),
  parameter int CHUNK_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHUNK_W-1:0]   cfg_chunks,
`ifdef ADDER_TREE_SEQ_BIAS_EN
  input  logic [ACC_W-1:0]     cfg_bias,
`endif
  output logic                 busy,
  output logic                 done,
  adder_tree_sequencer_if.slave bus
);

  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << DATA_BITWIDTH) - 64'd1);

  seq_state_t               state;
  logic [CHUNK_W-1:0]       cfg_q;
  logic [CHUNK_W-1:0]       chunk_cnt;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         init_val;
  logic                     first_q;      // next valid tag is the job's first
  logic                     last_seen_q;  // last tag has been accumulated
  logic                     out_valid_q;
  logic [DATA_BITWIDTH-1:0] out_data_q;
  logic [ACC_W-1:0]         out_acc_q;
  logic                     accept;
  tag_t                     tag_in;
  tag_t                     tag_out;

`ifdef ADDER_TREE_SEQ_BIAS_EN
  logic [ACC_W-1:0] bias_q;
  assign init_val = bias_q;
`else
  assign init_val = '0;
`endif

  function automatic logic [DATA_BITWIDTH-1:0] relu(input logic [ACC_W-1:0] v);
    if (v[ACC_W-1])     return '0;
    else if (v > OUT_MAX) return '1;
    else                return v[DATA_BITWIDTH-1:0];
  endfunction

  assign bus.in_ready  = (state == ST_FEED);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.tree_load = accept;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_acc   = out_acc_q;
  assign busy          = (state != ST_IDLE);
  assign done          = out_valid_q && bus.out_ready;

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.last  = accept && (chunk_cnt == cfg_q - CHUNK_W'(1));
  end

  tag_delay_line #(
    .DEPTH   (TREE_LATENCY)
  ) u_tags (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg_q       <= '0;
      chunk_cnt   <= '0;
      acc         <= '0;
      first_q     <= 1'b0;
      last_seen_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
`ifdef ADDER_TREE_SEQ_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      // Only tagged root sums belong to the job; everything else is ignored.
      if (tag_out.valid) begin
        acc     <= (first_q ? init_val : acc) + bus.tree_sum;
        first_q <= 1'b0;
        if (tag_out.last) last_seen_q <= 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_q       <= (cfg_chunks == '0) ? CHUNK_W'(1) : cfg_chunks;
            chunk_cnt   <= '0;
            first_q     <= 1'b1;
            last_seen_q <= 1'b0;
`ifdef ADDER_TREE_SEQ_BIAS_EN
            bias_q      <= cfg_bias;
`endif
            state       <= ST_FEED;
          end
        end
        ST_FEED: begin
          if (accept) begin
            chunk_cnt <= chunk_cnt + CHUNK_W'(1);
            if (tag_in.last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // acc already holds the final sum one cycle after the last tag.
          if (last_seen_q) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= acc;
            out_data_q  <= relu(acc);
            state       <= ST_OUTPUT;
          end
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// tb_adder_tree_sequencer -- self-checking bench for adder_tree_sequencer.
// An adder tree is modelled as a TREE_LATENCY-deep pipeline of root sums
// (garbage in non-load slots); expected results come from plain arithmetic
// over each job's list of sums. Build with ADDER_TREE_SEQ_BIAS_EN defined to
// exercise the bias input.
module tb_adder_tree_sequencer;

  localparam int DW  = 8;
  localparam int BR  = 32;
  localparam int TL  = 6;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_chunks;
  logic          busy;
  logic          done;
`ifdef ADDER_TREE_SEQ_BIAS_EN
  logic [31:0]   cfg_bias;
`endif

  adder_tree_sequencer_if #(.DATA_BITWIDTH(DW)) bus ();

  adder_tree_sequencer #(
    .DATA_BITWIDTH   (DW),
    .BREADTH_OF_TREE (BR),
    .CHUNK_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_chunks (cfg_chunks),
`ifdef ADDER_TREE_SEQ_BIAS_EN
    .cfg_bias   (cfg_bias),
`endif
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Tree model: the value presented with a launched beat reappears on the
  // root TL cycles later; slots without a launch carry random garbage.
  logic [31:0] beat_sum;
  logic [31:0] pipe [TL];
  assign bus.tree_sum = pipe[TL-1];

  int cyc        = 0;
  int load_cnt   = 0;
  int accept_cyc = 0;

  always @(posedge clk) begin
    for (int i = TL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= bus.tree_load ? beat_sum : $urandom();
    cyc = cyc + 1;
    if (bus.tree_load) begin
      load_cnt   = load_cnt + 1;
      accept_cyc = cyc;
    end
  end

  logic [31:0] job_sums [16];

  function automatic logic [31:0] relu_ref(input logic [31:0] v);
    if ($signed(v) < 0) return 0;
    if (v > 32'd255)    return 255;
    return v;
  endfunction

  // Runs one job: nbeats sums from job_sums, random in_valid gaps, then holds
  // out_ready low for 'hold' cycles (with spurious start pulses) before the handshake.
  task automatic run_job(input string nm, input int cfg, input int nbeats,
                         input logic [31:0] bias, input int gap_pct, input int hold);
    logic [31:0] exp_acc;
    logic [31:0] exp_data;
    int          loads0;
    int          t;
    exp_acc = 0;
`ifdef ADDER_TREE_SEQ_BIAS_EN
    exp_acc = bias;
`endif
    for (int i = 0; i < nbeats; i++) exp_acc = exp_acc + job_sums[i];
    exp_data = relu_ref(exp_acc);
    loads0   = load_cnt;

    @(posedge clk); #1;
    start      = 1'b1;
    cfg_chunks = CW'(cfg);
`ifdef ADDER_TREE_SEQ_BIAS_EN
    cfg_bias   = bias;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, "_feed_ready"}, 32'(bus.in_ready), 1);

    for (int i = 0; i < nbeats; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      beat_sum     = job_sums[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    beat_sum     = $urandom();

    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) begin
      check({nm, "_out_valid_timeout"}, 0, 1);
      return;
    end
    check({nm, "_latency"},  32'(cyc - accept_cyc), TL + 1);
    check({nm, "_out_acc"},  bus.out_acc, exp_acc);
    check({nm, "_out_data"}, 32'(bus.out_data), exp_data);
    check({nm, "_loads"},    32'(load_cnt - loads0), nbeats);
    check({nm, "_busy"},     32'(busy), 1);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      start      = 1'b1;
      cfg_chunks = 8'd5;
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(bus.out_valid), 1);
      check({nm, "_hold_acc"},   bus.out_acc, exp_acc);
      check({nm, "_hold_data"},  32'(bus.out_data), exp_data);
      check({nm, "_hold_ready"}, 32'(bus.in_ready), 0);
      check({nm, "_hold_done"},  32'(done), 0);
    end

    @(posedge clk); #1;
    start         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_done_pulse"}, 32'(done), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({nm, "_done_clear"}, 32'(done), 0);
    check({nm, "_idle_busy"},  32'(busy), 0);
    check({nm, "_idle_valid"}, 32'(bus.out_valid), 0);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    cfg_chunks    = '0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    beat_sum      = '0;
`ifdef ADDER_TREE_SEQ_BIAS_EN
    cfg_bias      = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      32'(busy), 0);
    check("rst_done",      32'(done), 0);
    check("rst_in_ready",  32'(bus.in_ready), 0);
    check("rst_tree_load", 32'(bus.tree_load), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data",  32'(bus.out_data), 0);
    check("rst_out_acc",   bus.out_acc, 0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    job_sums[0] = 100;
    run_job("single", 1, 1, 0, 0, 0);

    job_sums[0] = 50; job_sums[1] = -32'sd20; job_sums[2] = 30;
    run_job("gaps", 3, 3, 0, 50, 0);

    job_sums[0] = 200; job_sums[1] = 100;
    run_job("clamp", 2, 2, 0, 20, 0);

    job_sums[0] = -32'sd5;
    run_job("negative", 1, 1, 0, 0, 0);

    job_sums[0] = 42;
    run_job("cfg_zero", 0, 1, 0, 0, 0);

    job_sums[0] = 10; job_sums[1] = 20;
    run_job("backpressure", 2, 2, 0, 0, 10);

    // Abandon a job while its sum is still inside the tree.
    @(posedge clk); #1;
    start      = 1'b1;
    cfg_chunks = 8'd1;
    @(posedge clk); #1;
    start        = 1'b0;
    bus.in_valid = 1'b1;
    beat_sum     = 32'd999;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",  32'(busy), 0);
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_acc",   bus.out_acc, 0);
    job_sums[0] = 7;
    run_job("after_rst", 1, 1, 0, 0, 0);

`ifdef ADDER_TREE_SEQ_BIAS_EN
    job_sums[0] = 4; job_sums[1] = 3;
    run_job("bias", 2, 2, -32'sd10, 0, 0);
`endif

    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        job_sums[i] = ($urandom_range(1) == 1) ? 32'($urandom_range(0, 120)) - 32'd40
                                               : $urandom();
      run_job("random", n, n, $urandom_range(0, 64) - 32, 30, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/adder_tree_sequencer.md
ADDER_TREE_SEQUENCER -- requirements
Module: adder_tree_sequencer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_BITWIDTH, 8, width of the rectified output.
- BREADTH_OF_TREE, 32, tree leaf count (power of two).
- TREE_LATENCY, $clog2(BREADTH_OF_TREE)+1, cycles from a tree input beat to its root sum.
- CHUNK_W, 8, width of the chunk-count config.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  single clock; one clock, all logic on posedge clk.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job start pulse.
- cfg_chunks  in  CHUNK_W  tree-width vectors per job.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  sequencer accepts vector.
- tree_load  out  1  a vector is launched into the tree this cycle.
- tree_sum  in  32  raw root sum from the tree.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_BITWIDTH  rectified result.
- out_acc  out  32  raw signed accumulator.

Function
REQ-003 The FSM SHALL have states IDLE, FEED, DRAIN and OUTPUT.
REQ-004 In IDLE, start SHALL latch cfg_chunks, with 0 treated as 1, clear the chunk counter and go to FEED; start SHALL be ignored in any other state.
REQ-005 in_ready SHALL be 1 only in FEED; tree_load SHALL equal in_valid && in_ready.
REQ-006 Each accepted beat SHALL increment the chunk counter and push a tag {valid=1, last=(count==cfg-1)} into a TREE_LATENCY-deep delay line; all other cycles SHALL push {0,0}.
REQ-007 Acceptance of the last beat SHALL move FEED to DRAIN in the next cycle.
REQ-008 When a valid tag exits the delay line, the sequencer SHALL sample tree_sum:
- first tag of the job: acc <= init + tree_sum;
- later tags: acc <= acc + tree_sum.
REQ-009 Accumulation SHALL be 32-bit two's-complement with wrap-around; there is no overflow flag.
REQ-010 The cycle after the last tag exits, the FSM SHALL be in OUTPUT with out_valid=1. This is TREE_LATENCY+1 cycles after the last accept.
REQ-011 out_data SHALL be a ReLU of acc: 0 if acc<0, 2^DATA_BITWIDTH-1 if acc exceeds that value, else acc[DATA_BITWIDTH-1:0].
REQ-012 out_valid, out_data and out_acc SHALL be held stable until out_ready=1.
REQ-013 On the out_valid && out_ready handshake, the FSM SHALL go to IDLE and assert done for exactly that cycle.
REQ-014 busy SHALL be 1 in FEED, DRAIN and OUTPUT.
REQ-015 Tree outputs whose tag valid=0 SHALL never modify acc.

Reset
REQ-016 rst SHALL force:
- state IDLE, all delay-line tags 0, counter 0, acc 0;
- in_ready, tree_load, busy, done and out_valid to 0;
- out_data and out_acc to 0.
REQ-017 rst mid-job SHALL abandon the job. Sums still in flight in the tree SHALL be discarded because their tags are cleared.

Configuration
REQ-018 With ADDER_TREE_SEQ_BIAS_EN defined:
- a cfg_bias[31:0] input SHALL exist;
- cfg_bias SHALL be latched on start;
- init SHALL equal that latched bias.
REQ-019 Without ADDER_TREE_SEQ_BIAS_EN, cfg_bias SHALL be absent and init SHALL be 0.

Structure
REQ-020 A shared package adder_tree_pkg SHALL hold:
- the FSM state typedef;
- ACC_W=32;
- a tree-latency function of breadth.
REQ-021 The tag delay line SHALL be the sub-module tag_delay_line, parameterised by DEPTH and reset by rst.

Verification
REQ-022 The bench SHALL cover these scenarios (BREADTH_OF_TREE=32, TREE_LATENCY=6, DATA_BITWIDTH=8):
- Single chunk: cfg_chunks=1, tree_sum=100 → out_valid 7 cycles after accept, out_data=100, out_acc=100, done pulse on handshake.
- Multi-chunk with in_valid gaps: cfg_chunks=3, sums 50, -20, 30 → out_acc=60, out_data=60, exactly 3 tree_load pulses.
- Clamp and negative:
  - sums 200 and 100 → out_acc=300, out_data=255;
  - sum -5 → out_data=0, out_acc=0xFFFFFFFB.
- Backpressure: out_ready=0 for 10 cycles → outputs stable, in_ready=0 throughout, start ignored; done only on the handshake.
- Reset mid-DRAIN: rst for 1 cycle, then a new job with cfg_chunks=1, sum 7 → out_acc=7; the stale in-flight sum is not added.
- ADDER_TREE_SEQ_BIAS_EN defined, cfg_bias=-10, cfg_chunks=2, sums 4 and 3 → out_acc=-3, out_data=0.
